// File: rtl/fp_fir_coeff_ctrl.sv
// fp_fir_coeff_ctrl: ping-pong fp32 coefficient bank and commit sequencer for
// the fp_bandpass_fir filter. A commit stalls upstream, drains the filter
// pipeline, swaps the active/shadow banks in one cycle, and optionally purges
// the delay line with zero samples.
// Optional feature macro: FP_FIR_ZERO_FLUSH_EN (enables the FLUSH state).
module fp_fir_coeff_ctrl #(
    parameter int TAP_CNT  = 31,
    parameter int PIPE_LAT = 8,
    parameter int ADDR_W   = $clog2(TAP_CNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_wr_en,
    input  logic [ADDR_W-1:0]       cfg_wr_addr,
    input  logic [31:0]             cfg_wr_data,
    input  logic                    cfg_commit,
    output logic                    cfg_busy,
    output logic                    cfg_err,
    output logic                    swap_done,
    input  logic                    s_valid,
    input  logic [31:0]             s_data,
    output logic                    s_ready,
    output logic                    f_valid_in,
    output logic [31:0]             f_data_in,
    output logic [TAP_CNT*32-1:0]   coeff_flat,
    output logic                    bank_sel
);

    localparam int CNT_W = $clog2(TAP_CNT + PIPE_LAT + 1);
    // Counters run down to zero, so the load value is one less than the span.
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(PIPE_LAT - 1);
`ifdef FP_FIR_ZERO_FLUSH_EN
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(TAP_CNT - 1);
`endif
    // One extra bit so TAP_CNT itself is representable for the range check.
    localparam logic [ADDR_W:0] TAP_LIM = (ADDR_W + 1)'(TAP_CNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       bank_sel_q;
    logic [TAP_CNT-1:0][31:0]   bank0_q, bank1_q;
    logic [TAP_CNT-1:0][31:0]   coeff_q;

    logic wr_bad_addr, wr_in_swap, wr_ok, commit_ign;

    // Classify the config port activity for this cycle.
    always_comb begin
        wr_bad_addr = cfg_wr_en && ({1'b0, cfg_wr_addr} >= TAP_LIM);
        wr_in_swap  = cfg_wr_en && (state_q == SWAP);
        wr_ok       = cfg_wr_en && !wr_bad_addr && !wr_in_swap;
        commit_ign  = cfg_commit && (state_q != IDLE);
        err_d       = err_q | wr_bad_addr | wr_in_swap | commit_ign;
    end

    // Sequencer next-state, counter and datapath steering.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        s_ready    = 1'b0;
        f_valid_in = 1'b0;
        f_data_in  = 32'h0000_0000;
        unique case (state_q)
            IDLE: begin
                s_ready    = 1'b1;
                f_valid_in = s_valid;
                f_data_in  = s_data;
                if (cfg_commit) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LD;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = SWAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SWAP: begin
`ifdef FP_FIR_ZERO_FLUSH_EN
                state_d = FLUSH;
                cnt_d   = FLUSH_LD;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
            FLUSH: begin
`ifdef FP_FIR_ZERO_FLUSH_EN
                f_valid_in = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, sticky error and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Shadow bank writes; the active bank is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank0_q <= '0;
            bank1_q <= '0;
        end else if (wr_ok) begin
            if (bank_sel_q) bank0_q[cfg_wr_addr] <= cfg_wr_data;
            else            bank1_q[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Bank pointer flips at the end of SWAP; coeff register follows one cycle
    // later. The active bank is static outside a swap, so coeff_q only moves then.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q <= 1'b0;
            coeff_q    <= '0;
        end else begin
            if (state_q == SWAP) bank_sel_q <= ~bank_sel_q;
            coeff_q <= bank_sel_q ? bank1_q : bank0_q;
        end
    end

    assign cfg_busy   = (state_q != IDLE);
    assign cfg_err    = err_q;
    assign swap_done  = done_q;
    assign bank_sel   = bank_sel_q;
    assign coeff_flat = coeff_q;

endmodule
